// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the sequential approximate multiplier.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT      = 2'b00,
    MODE_APPROX_ADD = 2'b01,
    MODE_APPROX_OR  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [7:0] APPROX_LO_MASK = 8'hFC;

  // The reserved encoding 2'b11 behaves as exact.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_APPROX_ADD;
      2'b10:   return MODE_APPROX_OR;
      default: return MODE_EXACT;
    endcase
  endfunction

endpackage

// File: rtl/tile_mul_4x4.sv
// Combinational 4x4 nibble multiplier with an optional approximate low-bit path.
module tile_mul_4x4
  import approx_mult_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       approx,
  output logic [7:0] p8
);

  logic [7:0] exact_c;
  logic [1:0] lo_c;

  // Approximate tile keeps the exact upper six bits and rebuilds bits 1:0 from a cheap OR.
  always_comb begin
    exact_c = 8'(a4) * 8'(b4);
    lo_c    = {(a4[1] & b4[0]) | (a4[0] & b4[1]), a4[0] & b4[0]};
    if (approx) begin
      p8 = (exact_c & APPROX_LO_MASK) | {6'b0, lo_c};
    end else begin
      p8 = exact_c;
    end
  end

endmodule

// File: rtl/approx_mult_seq.sv
// Iterative approximate multiplier: one 4x4 nibble tile per clock over a (W/4)^2 grid.
// Define APPROX_MULT_ERRSTAT_EN to add the exact shadow accumulator and the err output.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned APPROX_LVL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] r
`ifdef APPROX_MULT_ERRSTAT_EN
  ,
  output logic [2*W-1:0] err
`endif
);

  localparam int unsigned N  = W / 4;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * W;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] r_q, r_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic [3:0]    a_nib_c, b_nib_c;
  logic [CW:0]   sum_ij_c;
  logic          use_approx_c;
  logic          last_tile_c;
  logic [7:0]    tile_p_c;
  logic [PW-1:0] shifted_c;
  logic [PW-1:0] acc_next_c;

  // Nibble mux and tile selection for the current (i,j).
  always_comb begin
    a_nib_c      = 4'(a_q >> {i_q, 2'b00});
    b_nib_c      = 4'(b_q >> {j_q, 2'b00});
    sum_ij_c     = (CW+1)'(i_q) + (CW+1)'(j_q);
    use_approx_c = ((mode_q == MODE_APPROX_ADD) || (mode_q == MODE_APPROX_OR)) &&
                   (32'(sum_ij_c) < APPROX_LVL);
    last_tile_c  = (i_q == LAST) && (j_q == LAST);
  end

  tile_mul_4x4 u_tile (
    .a4     (a_nib_c),
    .b4     (b_nib_c),
    .approx (use_approx_c),
    .p8     (tile_p_c)
  );

  always_comb begin
    shifted_c = PW'(tile_p_c) << {sum_ij_c, 2'b00};
    if (mode_q == MODE_APPROX_OR) begin
      acc_next_c = acc_q | shifted_c;
    end else begin
      acc_next_c = acc_q + shifted_c;
    end
  end

`ifdef APPROX_MULT_ERRSTAT_EN
  logic [PW-1:0] exact_q, exact_d;
  logic [PW-1:0] err_q, err_d;
  logic [7:0]    tile_exact_c;
  logic [PW-1:0] exact_next_c;

  tile_mul_4x4 u_tile_exact (
    .a4     (a_nib_c),
    .b4     (b_nib_c),
    .approx (1'b0),
    .p8     (tile_exact_c)
  );

  always_comb begin
    exact_next_c = exact_q + (PW'(tile_exact_c) << {sum_ij_c, 2'b00});
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
`ifdef APPROX_MULT_ERRSTAT_EN
    exact_d     = exact_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = decode_mode(mode);
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
`ifdef APPROX_MULT_ERRSTAT_EN
          exact_d = '0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next_c;
`ifdef APPROX_MULT_ERRSTAT_EN
        exact_d = exact_next_c;
`endif
        if (i_q == LAST) begin
          i_d = '0;
          j_d = j_q + CW'(1);
        end else begin
          i_d = i_q + CW'(1);
        end
        // Final tile: publish the result on the same edge it is accumulated.
        if (last_tile_c) begin
          i_d         = '0;
          j_d         = '0;
          r_d         = acc_next_c;
          out_valid_d = 1'b1;
`ifdef APPROX_MULT_ERRSTAT_EN
          err_d       = exact_next_c - acc_next_c;
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_EXACT;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef APPROX_MULT_ERRSTAT_EN
      exact_q     <= '0;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef APPROX_MULT_ERRSTAT_EN
      exact_q     <= exact_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
`ifdef APPROX_MULT_ERRSTAT_EN
  assign err       = err_q;
`endif

endmodule
